// File: rtl/csr_unit_m.sv
// Machine-mode CSR file: CSRRW/S/C access, mcycle/minstret counters, trap entry and mret.
// Optional build macro CSR_TIMER_IRQ_EN adds mie/mip with the machine timer interrupt.
module csr_unit_m #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     CNT_WIDTH   = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_index,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] imm_csr,
    input  logic [1:0]      csr_ctrl,
    input  logic            csr_src,
    input  logic            retire_valid,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            timer_irq,
    output logic [XLEN-1:0] csr_read,
    output logic            csr_illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            irq_pending
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

    logic                 mie_q, mpie_q;
    logic [XLEN-1:0]      mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [CNT_WIDTH-1:0] mcycle_q, minstret_q;
`ifdef CSR_TIMER_IRQ_EN
    logic                 mtie_q;
`endif

    logic            implemented;
    logic [XLEN-1:0] rdata, op, wdata, vec_base, trap_target;
    logic            wr_en;

    always_comb begin
        implemented = 1'b1;
        rdata       = '0;
        case (csr_index)
            ADDR_MSTATUS: begin
                rdata[3] = mie_q;
                rdata[7] = mpie_q;
            end
            ADDR_MTVEC:    rdata = mtvec_q;
            ADDR_MSCRATCH: rdata = mscratch_q;
            ADDR_MEPC:     rdata = {mepc_q[XLEN-1:2], 2'b00};
            ADDR_MCAUSE:   rdata = mcause_q;
            ADDR_MCYCLE:   rdata = XLEN'(mcycle_q);
            ADDR_MINSTRET: rdata = XLEN'(minstret_q);
`ifdef CSR_TIMER_IRQ_EN
            ADDR_MIE:      rdata[7] = mtie_q;
            ADDR_MIP:      rdata[7] = timer_irq;
`endif
            default:       implemented = 1'b0;
        endcase
    end

    assign csr_read    = rdata;
    assign csr_illegal = (csr_ctrl != 2'b00) && !implemented;
    assign op          = csr_src ? imm_csr : rs1_data;

    always_comb begin
        case (csr_ctrl)
            2'b01:   wdata = op;
            2'b10:   wdata = rdata | op;
            2'b11:   wdata = rdata & ~op;
            default: wdata = rdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read; trap and mret swallow the access.
    assign wr_en = implemented && ((csr_ctrl == 2'b01) || (csr_ctrl[1] && (op != '0)))
                   && !trap_valid && !mret_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
`ifdef CSR_TIMER_IRQ_EN
            mtie_q     <= 1'b0;
`endif
        end else begin
            mcycle_q   <= mcycle_q + CNT_WIDTH'(1);
            minstret_q <= minstret_q + CNT_WIDTH'(retire_valid);
            // Later assignments override the counter increments above.
            if (wr_en) begin
                case (csr_index)
                    ADDR_MSTATUS: begin
                        mie_q  <= wdata[3];
                        mpie_q <= wdata[7];
                    end
                    ADDR_MTVEC:    mtvec_q    <= wdata;
                    ADDR_MSCRATCH: mscratch_q <= wdata;
                    ADDR_MEPC:     mepc_q     <= wdata;
                    ADDR_MCAUSE:   mcause_q   <= wdata;
                    ADDR_MCYCLE:   mcycle_q   <= wdata[CNT_WIDTH-1:0];
                    ADDR_MINSTRET: minstret_q <= wdata[CNT_WIDTH-1:0];
`ifdef CSR_TIMER_IRQ_EN
                    ADDR_MIE:      mtie_q     <= wdata[7];
`endif
                    default: ;
                endcase
            end
            if (trap_valid) begin
                mepc_q   <= trap_pc;
                mcause_q <= trap_cause;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret_valid) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end
    end

    assign vec_base    = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target = ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1])
                         ? vec_base + {trap_cause[XLEN-3:0], 2'b00} : vec_base;

    assign redirect_valid = trap_valid | mret_valid;
    assign redirect_pc    = trap_valid ? trap_target : {mepc_q[XLEN-1:2], 2'b00};

`ifdef CSR_TIMER_IRQ_EN
    assign irq_pending = mie_q & mtie_q & timer_irq;
`else
    logic unused_timer_irq;
    assign unused_timer_irq = timer_irq;
    assign irq_pending      = 1'b0;
`endif

endmodule

// File: tb/tb_csr_unit_m.sv
// Self-checking bench for csr_unit_m: directed scenarios plus a randomized run
// against a register-level reference model. Honours CSR_TIMER_IRQ_EN if defined.
module tb_csr_unit_m;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_index;
    logic [63:0] rs1_data, imm_csr, trap_cause, trap_pc;
    logic [1:0]  csr_ctrl;
    logic        csr_src, retire_valid, trap_valid, mret_valid, timer_irq;
    logic [63:0] csr_read, redirect_pc;
    logic        csr_illegal, redirect_valid, irq_pending;

    // Narrow-counter instance for the wrap scenario.
    logic [11:0] c8_index;
    logic [1:0]  c8_ctrl;
    logic [63:0] c8_rs1, c8_read, c8_rpc;
    logic        c8_ill, c8_rv, c8_irq;

    int checks   = 0;
    int failures = 0;

`ifdef CSR_TIMER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    csr_unit_m #(.XLEN(64), .CNT_WIDTH(64), .MTVEC_RESET(64'h0)) dut (
        .clk(clk), .rst(rst), .csr_index(csr_index), .rs1_data(rs1_data),
        .imm_csr(imm_csr), .csr_ctrl(csr_ctrl), .csr_src(csr_src),
        .retire_valid(retire_valid), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .mret_valid(mret_valid), .timer_irq(timer_irq),
        .csr_read(csr_read), .csr_illegal(csr_illegal), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .irq_pending(irq_pending)
    );

    csr_unit_m #(.XLEN(64), .CNT_WIDTH(8), .MTVEC_RESET(64'h0)) dut8 (
        .clk(clk), .rst(rst), .csr_index(c8_index), .rs1_data(c8_rs1),
        .imm_csr(64'h0), .csr_ctrl(c8_ctrl), .csr_src(1'b0),
        .retire_valid(1'b0), .trap_valid(1'b0), .trap_cause(64'h0),
        .trap_pc(64'h0), .mret_valid(1'b0), .timer_irq(1'b0),
        .csr_read(c8_read), .csr_illegal(c8_ill), .redirect_valid(c8_rv),
        .redirect_pc(c8_rpc), .irq_pending(c8_irq)
    );

    // Reference model state: architectural values as software would read them.
    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_index = 12'h000; rs1_data = '0; imm_csr = '0; csr_ctrl = 2'b00; csr_src = 1'b0;
        retire_valid = 1'b0; trap_valid = 1'b0; trap_cause = '0; trap_pc = '0;
        mret_valid = 1'b0; timer_irq = 1'b0;
    endtask

    task automatic access(input logic [11:0] idx, input logic [1:0] ctrl, input logic [63:0] v,
                          input logic src);
        idle();
        csr_index = idx; csr_ctrl = ctrl; csr_src = src;
        if (src) imm_csr = v; else rs1_data = v;
    endtask

    function automatic void model_reset();
        m_mstatus = '0; m_mie = '0; m_mtvec = '0; m_mscratch = '0;
        m_mepc = '0; m_mcause = '0; m_mcycle = '0; m_minstret = '0;
    endfunction

    function automatic void model_read(input logic [11:0] idx, input logic tirq,
                                       output logic [63:0] v, output logic impl);
        impl = 1'b1;
        v    = '0;
        case (idx)
            12'h300: v = m_mstatus;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00: v = m_mcycle;
            12'hB02: v = m_minstret;
            12'h304: if (IRQ_EN) v = m_mie; else impl = 1'b0;
            12'h344: if (IRQ_EN) v = tirq ? 64'h80 : 64'h0; else impl = 1'b0;
            default: impl = 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        logic [11:0] idx [7];
        idx = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02};
        idle(); rst = 1'b1;
        step(); step();
        for (int i = 0; i < 7; i++) begin
            csr_index = idx[i];
            #0.5;
            checks++;
            if (csr_read !== 64'h0) begin
                failures++;
                $display("FAIL reset_read[%h]: got %h expected 0", idx[i], csr_read);
            end
        end
        checks++;
        if ({csr_illegal, redirect_valid, irq_pending} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000",
                     {csr_illegal, redirect_valid, irq_pending});
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_idle_count();
        repeat (10) step();
        csr_index = 12'hB00;
        #1;
        checks++;
        if (csr_read !== 64'd10) begin
            failures++;
            $display("FAIL idle_mcycle: got %0d expected 10", csr_read);
        end
    endtask

    task automatic test_mcycle_rw();
        access(12'hB00, 2'b01, 64'h100, 1'b0);
        #1;
        checks++;
        if (csr_read !== 64'd10) begin
            failures++;
            $display("FAIL mcycle_rw_old: got %h expected a", csr_read);
        end
        step();
        access(12'hB00, 2'b00, 64'h0, 1'b0);
        #1;
        checks++;
        if (csr_read !== 64'h100) begin
            failures++;
            $display("FAIL mcycle_written: got %h expected 100", csr_read);
        end
        step();
        checks++;
        if (csr_read !== 64'h101) begin
            failures++;
            $display("FAIL mcycle_after: got %h expected 101", csr_read);
        end
    endtask

    task automatic test_trap_mret();
        access(12'h305, 2'b01, 64'h2000, 1'b0);
        step();
        access(12'h300, 2'b10, 64'h8, 1'b1);
        step();
        access(12'h300, 2'b00, 64'h0, 1'b0);
        #1;
        checks++;
        if (csr_read !== 64'h8) begin
            failures++;
            $display("FAIL mstatus_set: got %h expected 8", csr_read);
        end
        trap_valid = 1'b1; trap_cause = 64'd2; trap_pc = 64'h8000_0010;
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h2000) begin
            failures++;
            $display("FAIL trap_redirect: got %b/%h expected 1/2000", redirect_valid, redirect_pc);
        end
        step();
        access(12'h341, 2'b00, 64'h0, 1'b0);
        #0.5;
        checks++;
        if (csr_read !== 64'h8000_0010) begin
            failures++;
            $display("FAIL trap_mepc: got %h expected 80000010", csr_read);
        end
        csr_index = 12'h342;
        #0.5;
        checks++;
        if (csr_read !== 64'd2) begin
            failures++;
            $display("FAIL trap_mcause: got %h expected 2", csr_read);
        end
        csr_index = 12'h300;
        #0.5;
        checks++;
        if (csr_read !== 64'h80) begin
            failures++;
            $display("FAIL trap_mstatus: got %h expected 80", csr_read);
        end
        mret_valid = 1'b1;
        #0.5;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0010) begin
            failures++;
            $display("FAIL mret_redirect: got %b/%h expected 1/80000010",
                     redirect_valid, redirect_pc);
        end
        step();
        mret_valid = 1'b0;
        #1;
        checks++;
        if (csr_read !== 64'h88) begin
            failures++;
            $display("FAIL mret_mstatus: got %h expected 88", csr_read);
        end
    endtask

    task automatic test_vectored();
        access(12'h305, 2'b01, 64'h2001, 1'b0);
        step();
        idle();
        trap_valid = 1'b1; trap_cause = (64'h1 << 63) | 64'd7; trap_pc = 64'h40;
        #1;
        checks++;
        if (redirect_pc !== 64'h201C) begin
            failures++;
            $display("FAIL vectored_irq: got %h expected 201c", redirect_pc);
        end
        trap_cause = 64'd7;
        #1;
        checks++;
        if (redirect_pc !== 64'h2000) begin
            failures++;
            $display("FAIL vectored_exc: got %h expected 2000", redirect_pc);
        end
        step();
        idle();
    endtask

    task automatic test_illegal_nowrite();
        access(12'h340, 2'b01, 64'h55, 1'b0);
        step();
        access(12'h340, 2'b11, 64'h0, 1'b1);
        step();
        access(12'h340, 2'b00, 64'h0, 1'b0);
        #1;
        checks++;
        if (csr_read !== 64'h55) begin
            failures++;
            $display("FAIL rc_zero_nowrite: got %h expected 55", csr_read);
        end
        access(12'h7C0, 2'b01, 64'h123, 1'b0);
        #1;
        checks++;
        if (csr_illegal !== 1'b1 || csr_read !== 64'h0) begin
            failures++;
            $display("FAIL illegal_7c0: got %b/%h expected 1/0", csr_illegal, csr_read);
        end
        csr_ctrl = 2'b00;
        #1;
        checks++;
        if (csr_illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_noaccess: got %b expected 0", csr_illegal);
        end
        access(12'h304, 2'b01, 64'h0, 1'b0);
        #1;
        checks++;
        if (csr_illegal !== !IRQ_EN) begin
            failures++;
            $display("FAIL illegal_mie: got %b expected %b", csr_illegal, !IRQ_EN);
        end
        access(12'h341, 2'b01, 64'hDEAD0, 1'b0);
        trap_valid = 1'b1; trap_cause = 64'd3; trap_pc = 64'h1234;
        step();
        access(12'h340, 2'b01, 64'h77, 1'b0);
        mret_valid = 1'b1;
        step();
        access(12'h341, 2'b00, 64'h0, 1'b0);
        #0.5;
        checks++;
        if (csr_read !== 64'h1234) begin
            failures++;
            $display("FAIL trap_beats_write: got %h expected 1234", csr_read);
        end
        csr_index = 12'h340;
        #0.5;
        checks++;
        if (csr_read !== 64'h55) begin
            failures++;
            $display("FAIL mret_drops_write: got %h expected 55", csr_read);
        end
    endtask

    task automatic test_wrap_irq();
        c8_index = 12'hB00; c8_ctrl = 2'b01; c8_rs1 = 64'hFF;
        step();
        c8_ctrl = 2'b00;
        #1;
        checks++;
        if (c8_read !== 64'hFF) begin
            failures++;
            $display("FAIL cnt8_written: got %h expected ff", c8_read);
        end
        step();
        checks++;
        if (c8_read !== 64'h0) begin
            failures++;
            $display("FAIL cnt8_wrap: got %h expected 0", c8_read);
        end
        access(12'h300, 2'b10, 64'h8, 1'b1);
        step();
        access(12'h304, 2'b10, 64'h80, 1'b0);
        step();
        idle();
        timer_irq = 1'b1;
        #1;
        checks++;
        if (irq_pending !== IRQ_EN) begin
            failures++;
            $display("FAIL irq_pending_on: got %b expected %b", irq_pending, IRQ_EN);
        end
        timer_irq = 1'b0;
        #1;
        checks++;
        if (irq_pending !== 1'b0) begin
            failures++;
            $display("FAIL irq_pending_off: got %b expected 0", irq_pending);
        end
    endtask

    task automatic test_random();
        logic [11:0] pool [11];
        logic [63:0] old, op, w, exp_read, exp_rpc, base;
        logic [63:0] n_mstatus, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mcycle, n_minstret;
        logic        impl, wr, exp_ill, exp_irq;
        pool = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                 12'hB00, 12'hB02, 12'h7C0, 12'h301};
        idle(); rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int it = 0; it < 600; it++) begin
            rst          = ($urandom_range(0, 59) == 0);
            csr_index    = pool[$urandom_range(0, 10)];
            csr_ctrl     = 2'($urandom_range(0, 3));
            csr_src      = 1'($urandom_range(0, 1));
            rs1_data     = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            imm_csr      = 64'($urandom_range(0, 31));
            retire_valid = 1'($urandom_range(0, 1));
            trap_valid   = ($urandom_range(0, 7) == 0);
            mret_valid   = ($urandom_range(0, 7) == 0);
            trap_cause   = {$urandom, $urandom};
            trap_pc      = {$urandom, $urandom};
            timer_irq    = 1'($urandom_range(0, 1));
            #1;
            model_read(csr_index, timer_irq, old, impl);
            exp_read = impl ? old : 64'h0;
            exp_ill  = (csr_ctrl != 2'b00) && !impl;
            op       = csr_src ? imm_csr : rs1_data;
            wr       = impl && (csr_ctrl == 2'b01 || (csr_ctrl >= 2'b10 && op != 0))
                       && !trap_valid && !mret_valid;
            w        = (csr_ctrl == 2'b01) ? op : (csr_ctrl == 2'b10) ? (old | op) : (old & ~op);
            base     = m_mtvec & ~64'h3;
            if (trap_valid && m_mtvec[1:0] == 2'b01 && trap_cause[63])
                exp_rpc = base + 4 * (trap_cause & ~(64'h1 << 63));
            else if (trap_valid)
                exp_rpc = base;
            else
                exp_rpc = m_mepc;
            exp_irq = IRQ_EN && m_mstatus[3] && m_mie[7] && timer_irq;
            checks++;
            if (csr_read !== exp_read || csr_illegal !== exp_ill) begin
                failures++;
                $display("FAIL rand_read[%0d] idx=%h: got %h/%b expected %h/%b", it, csr_index,
                         csr_read, csr_illegal, exp_read, exp_ill);
            end
            checks++;
            if (redirect_valid !== (trap_valid | mret_valid) ||
                ((trap_valid | mret_valid) && redirect_pc !== exp_rpc)) begin
                failures++;
                $display("FAIL rand_redirect[%0d]: got %b/%h expected %b/%h", it, redirect_valid,
                         redirect_pc, trap_valid | mret_valid, exp_rpc);
            end
            checks++;
            if (irq_pending !== exp_irq) begin
                failures++;
                $display("FAIL rand_irq[%0d]: got %b expected %b", it, irq_pending, exp_irq);
            end
            n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
            n_mepc = m_mepc; n_mcause = m_mcause;
            n_mcycle = m_mcycle + 1; n_minstret = m_minstret + 64'(retire_valid);
            if (wr) begin
                case (csr_index)
                    12'h300: n_mstatus  = w & 64'h88;
                    12'h304: n_mie      = w & 64'h80;
                    12'h305: n_mtvec    = w;
                    12'h340: n_mscratch = w;
                    12'h341: n_mepc     = w & ~64'h3;
                    12'h342: n_mcause   = w;
                    12'hB00: n_mcycle   = w;
                    12'hB02: n_minstret = w;
                    default: ;
                endcase
            end
            if (trap_valid) begin
                n_mepc    = trap_pc & ~64'h3;
                n_mcause  = trap_cause;
                n_mstatus = m_mstatus[3] ? 64'h80 : 64'h0;
            end else if (mret_valid) begin
                n_mstatus = 64'h80 | (m_mstatus[7] ? 64'h8 : 64'h0);
            end
            step();
            if (rst) begin
                model_reset();
            end else begin
                m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
                m_mepc = n_mepc; m_mcause = n_mcause; m_mcycle = n_mcycle; m_minstret = n_minstret;
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        c8_index = 12'h0; c8_ctrl = 2'b00; c8_rs1 = '0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_idle_count();
        test_mcycle_rw();
        test_trap_mret();
        test_vectored();
        test_illegal_nowrite();
        test_wrap_irq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
